// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit controller.
package uart_pkg;

  // Default frame data width and TX FIFO depth.
  localparam int DATA_W         = 9;
  localparam int FIFO_DEPTH_DEF = 16;

  // Launch sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } tx_state_t;

  // Line configuration as seen by the transmitter.
  typedef struct packed {
    logic [1:0]  word_length;
    logic [15:0] baud_rate_cnt;
    logic        parity_en;
    logic        stop_bits;
    logic        set_break;
  } line_cfg_t;

  // A new frame may start only with data queued, no break requested and a
  // usable (non-zero) baud divisor.
  function automatic logic launch_ok(input logic       empty,
                                     input logic       set_break,
                                     input logic [15:0] baud_rate_cnt);
    return !empty && !set_break && (baud_rate_cnt != 16'd0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO with occupancy count and sticky overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     clr,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A pop on an empty FIFO is ignored; a push while full only lands when a
  // pop frees the slot in the same cycle.
  assign w_pop_ok  = pop && !w_empty;
  assign w_push_ok = push && (!w_full || w_pop_ok);

  // Storage array; contents are abandoned through the pointers, never cleared.
  always_ff @(posedge clk) begin
    if (w_push_ok && !clr) r_mem[r_wptr] <= wdata;
  end

  // Pointers, occupancy and sticky overflow; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
      if (push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  assign rdata    = r_mem[r_rptr];
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_ovf;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: queues host frames and launches them one at a
// time into the transmitter with a configuration snapshot per frame.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = uart_pkg::FIFO_DEPTH_DEF,
  parameter int DATA_W     = uart_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        fifo_clr,
  input  logic [1:0]                  cfg_word_length,
  input  logic [15:0]                 cfg_baud_rate_cnt,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_stop_bits,
  input  logic                        cfg_set_break,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        temt,
  output logic                        thre_irq,
  output logic [DATA_W-1:0]           tx_data,
  output logic [1:0]                  tx_word_length,
  output logic [15:0]                 tx_baud_rate_cnt,
  output logic                        tx_parity_en,
  output logic                        tx_stop_bits,
  output logic                        tx_set_break,
  output logic                        tx_start,
  input  logic                        tx_done
);

  import uart_pkg::*;

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic              w_pop;
  logic              w_load;
  logic              w_start;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic              w_empty;
  line_cfg_t         w_cfg;
  line_cfg_t         r_cfg;
  logic [DATA_W-1:0] r_data;
  logic              r_empty_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .wdata    (wr_data),
    .pop      (w_pop),
    .clr      (fifo_clr),
    .rdata    (w_fifo_rdata),
    .full     (full),
    .empty    (w_empty),
    .level    (level),
    .overflow (overflow)
  );

  assign empty = w_empty;

  // Gather the live configuration pins into one snapshot word.
  always_comb begin
    w_cfg               = '0;
    w_cfg.word_length   = cfg_word_length;
    w_cfg.baud_rate_cnt = cfg_baud_rate_cnt;
    w_cfg.parity_en     = cfg_parity_en;
    w_cfg.stop_bits     = cfg_stop_bits;
    w_cfg.set_break     = cfg_set_break;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (launch_ok(w_empty, cfg_set_break, cfg_baud_rate_cnt))
          w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // A flush on the edge that entered LOAD can leave nothing to pop;
        // fall back to IDLE rather than launch stale data.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_start     = 1'b1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame data and configuration snapshot, frozen until the next LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cfg  <= '0;
    end else if (w_load) begin
      r_data <= w_fifo_rdata;
      r_cfg  <= w_cfg;
    end
  end

  // Delayed empty used to spot the 0->1 edge for the THR-empty pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_empty_q <= 1'b1;
    else     r_empty_q <= w_empty;
  end

  assign thre_irq         = w_empty && !r_empty_q;
  assign temt             = w_empty && (r_state == ST_IDLE);
  assign tx_start         = w_start;
  assign tx_data          = r_data;
  assign tx_word_length   = r_cfg.word_length;
  assign tx_baud_rate_cnt = r_cfg.baud_rate_cnt;
  assign tx_parity_en     = r_cfg.parity_en;
  assign tx_stop_bits     = r_cfg.stop_bits;
  // Break tracks the pin live while idle so the line can be forced low
  // between frames; reset still wins so the output is 0 under reset.
  assign tx_set_break     = (r_state == ST_IDLE) ? (cfg_set_break && !rst)
                                                 : r_cfg.set_break;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed steps with random data and
// configuration, checked against a queue model of the frames still owed.
module tb_uart_tx_ctrl;

  localparam int DEPTH = 16;
  localparam int DW    = 9;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          fifo_clr;
  logic [1:0]    cfg_word_length;
  logic [15:0]   cfg_baud_rate_cnt;
  logic          cfg_parity_en;
  logic          cfg_stop_bits;
  logic          cfg_set_break;
  logic          full, empty, overflow;
  logic [LW-1:0] level;
  logic          temt, thre_irq;
  logic [DW-1:0] tx_data;
  logic [1:0]    tx_word_length;
  logic [15:0]   tx_baud_rate_cnt;
  logic          tx_parity_en, tx_stop_bits, tx_set_break, tx_start;
  logic          tx_done;

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .fifo_clr(fifo_clr),
    .cfg_word_length(cfg_word_length), .cfg_baud_rate_cnt(cfg_baud_rate_cnt),
    .cfg_parity_en(cfg_parity_en), .cfg_stop_bits(cfg_stop_bits),
    .cfg_set_break(cfg_set_break), .full(full), .empty(empty), .overflow(overflow),
    .level(level), .temt(temt), .thre_irq(thre_irq), .tx_data(tx_data),
    .tx_word_length(tx_word_length), .tx_baud_rate_cnt(tx_baud_rate_cnt),
    .tx_parity_en(tx_parity_en), .tx_stop_bits(tx_stop_bits),
    .tx_set_break(tx_set_break), .tx_start(tx_start), .tx_done(tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model: words accepted by the FIFO and not yet launched, in order.
  logic [DW-1:0] q_model [$];
  bit            mdl_ovf = 1'b0;
  int            start_cnt = 0;
  int            thre_cnt  = 0;
  int            done_dly  = 5;
  bit            inflight  = 1'b0;
  int            done_cnt  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter stand-in: answers each tx_start with tx_done after done_dly
  // cycles, and checks launch order and overlap against the model.
  initial begin
    logic [DW-1:0] exp_w;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        inflight = 1'b0;
        done_cnt = -1;
      end else begin
        if (thre_irq) thre_cnt++;
        if (done_cnt == 0) begin
          tx_done  = 1'b1;
          inflight = 1'b0;
          done_cnt = -1;
        end else if (done_cnt > 0) begin
          done_cnt--;
        end
        if (tx_start) begin
          start_cnt++;
          chk("no_overlap", 32'(inflight), 32'd0);
          inflight = 1'b1;
          done_cnt = done_dly;
          chk("start_has_word", 32'(q_model.size() > 0), 32'd1);
          if (q_model.size() > 0) begin
            exp_w = q_model.pop_front();
            chk("tx_data_order", 32'(tx_data), 32'(exp_w));
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle push; pop_same marks a push known to coincide with a pop.
  task automatic push(input logic [DW-1:0] d, input bit pop_same);
    wr_en   = 1'b1;
    wr_data = d;
    if (q_model.size() < DEPTH || pop_same) q_model.push_back(d);
    else mdl_ovf = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (temt && q_model.size() == 0 && !inflight) break;
    end
    chk(tag, 32'(temt), 32'd1);
    chk({tag, "_model"}, 32'(q_model.size()), 32'd0);
  endtask

  task automatic wait_start(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (tx_start) break;
    end
    chk(tag, 32'(tx_start), 32'd1);
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_level"}, 32'(level), 32'd0);
    chk({pfx, "_full"}, 32'(full), 32'd0);
    chk({pfx, "_empty"}, 32'(empty), 32'd1);
    chk({pfx, "_ovf"}, 32'(overflow), 32'd0);
    chk({pfx, "_temt"}, 32'(temt), 32'd1);
    chk({pfx, "_thre"}, 32'(thre_irq), 32'd0);
    chk({pfx, "_start"}, 32'(tx_start), 32'd0);
    chk({pfx, "_data"}, 32'(tx_data), 32'd0);
    chk({pfx, "_wl"}, 32'(tx_word_length), 32'd0);
    chk({pfx, "_baud"}, 32'(tx_baud_rate_cnt), 32'd0);
    chk({pfx, "_par"}, 32'(tx_parity_en), 32'd0);
    chk({pfx, "_stop"}, 32'(tx_stop_bits), 32'd0);
    chk({pfx, "_brk"}, 32'(tx_set_break), 32'd0);
  endtask

  initial begin
    int n, s0, t0;
    logic [1:0]  wl;
    logic [15:0] baud;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
    cfg_word_length = 2'd0; cfg_baud_rate_cnt = 16'd0; cfg_parity_en = 1'b0;
    cfg_stop_bits = 1'b0; cfg_set_break = 1'b1;

    // Reset values, with break requested on the pin to prove reset wins.
    step(3);
    chk_reset_outs("rst");
    cfg_set_break = 1'b0;
    rst = 1'b0;
    step(2);

    // First-frame latency and configuration capture.
    cfg_word_length = 2'd3; cfg_baud_rate_cnt = 16'd5208; cfg_parity_en = 1'b1;
    cfg_stop_bits = 1'b0; done_dly = 5;
    push(9'h0FF, 1'b0);
    chk("lat_e0_start", 32'(tx_start), 32'd0);
    chk("lat_e0_level", 32'(level), 32'd1);
    step();
    chk("lat_e1_start", 32'(tx_start), 32'd0);
    step();
    chk("lat_e2_start", 32'(tx_start), 32'd1);
    chk("lat_e2_data", 32'(tx_data), 32'h0FF);
    chk("lat_e2_baud", 32'(tx_baud_rate_cnt), 32'd5208);
    chk("lat_e2_par", 32'(tx_parity_en), 32'd1);
    chk("lat_e2_wl", 32'(tx_word_length), 32'd3);
    chk("lat_e2_thre", 32'(thre_irq), 32'd1);
    step();
    chk("lat_e3_start", 32'(tx_start), 32'd0);
    chk("lat_e3_temt", 32'(temt), 32'd0);
    wait_idle("first_idle", 60);

    // Queued bursts under random configuration; first round is 3 frames
    // with a 100-cycle transmitter.
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 3 : int'($urandom_range(1, 5));
      done_dly = (r == 0) ? 100 : int'($urandom_range(2, 20));
      cfg_baud_rate_cnt = 16'd0;
      step();
      for (int i = 0; i < n; i++) push(DW'($urandom), 1'b0);
      chk("burst_level", 32'(level), 32'(n));
      wl   = 2'($urandom_range(0, 3));
      baud = 16'($urandom_range(1, 65535));
      s0 = start_cnt; t0 = thre_cnt;
      cfg_word_length = wl; cfg_parity_en = 1'($urandom); cfg_stop_bits = 1'($urandom);
      cfg_baud_rate_cnt = baud;
      wait_idle("burst_drain", n * (done_dly + 10) + 20);
      chk("burst_starts", 32'(start_cnt - s0), 32'(n));
      chk("burst_thre", 32'(thre_cnt - t0), 32'd1);
      chk("burst_wl", 32'(tx_word_length), 32'(wl));
      chk("burst_baud", 32'(tx_baud_rate_cnt), 32'(baud));
    end

    // Overflow: 17 pushes with launches held off.
    cfg_baud_rate_cnt = 16'd0;
    step();
    for (int i = 0; i < DEPTH + 1; i++) push(DW'($urandom), 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'(mdl_ovf));
    chk("ovf_level", 32'(level), 32'(DEPTH));
    done_dly = 3;
    cfg_baud_rate_cnt = 16'd100;
    wait_idle("ovf_drain", DEPTH * 20);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_notfull", 32'(full), 32'd0);

    // Flush outranks a simultaneous push and clears overflow.
    cfg_baud_rate_cnt = 16'd0;
    push(DW'($urandom), 1'b0);
    push(DW'($urandom), 1'b0);
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = DW'($urandom);
    step();
    fifo_clr = 1'b0; wr_en = 1'b0;
    q_model.delete(); mdl_ovf = 1'b0;
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_thre", 32'(thre_irq), 32'd1);

    // Push into a full FIFO on the same edge as the LOAD pop.
    cfg_set_break = 1'b1; cfg_baud_rate_cnt = 16'd100;
    for (int i = 0; i < DEPTH; i++) push(DW'($urandom), 1'b0);
    chk("fullpop_full", 32'(full), 32'd1);
    cfg_set_break = 1'b0;
    step();
    push(DW'($urandom), 1'b1);
    chk("fullpop_level", 32'(level), 32'(DEPTH));
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    wait_idle("fullpop_drain", (DEPTH + 1) * 20);

    // Configuration frozen during BUSY; break does not abort a frame.
    done_dly = 40; cfg_word_length = 2'd3; cfg_baud_rate_cnt = 16'd50;
    push(DW'($urandom), 1'b0);
    wait_start("wl_start1", 10);
    step(2);
    cfg_word_length = 2'd1; cfg_set_break = 1'b1;
    step(5);
    chk("wl_hold", 32'(tx_word_length), 32'd3);
    chk("brk_latched", 32'(tx_set_break), 32'd0);
    chk("busy_temt", 32'(temt), 32'd0);
    wait_idle("brk_frame_done", 100);
    chk("brk_idle_live", 32'(tx_set_break), 32'd1);
    cfg_set_break = 1'b0;
    step();
    push(DW'($urandom), 1'b0);
    wait_start("wl_start2", 10);
    chk("wl_new", 32'(tx_word_length), 32'd1);
    wait_idle("wl_idle", 100);

    // Break holds two queued frames, then both launch in order.
    done_dly = 3; cfg_set_break = 1'b1;
    s0 = start_cnt;
    push(DW'($urandom), 1'b0);
    push(DW'($urandom), 1'b0);
    step(10);
    chk("brk_nostart", 32'(start_cnt - s0), 32'd0);
    chk("brk_out", 32'(tx_set_break), 32'd1);
    chk("brk_level", 32'(level), 32'd2);
    cfg_set_break = 1'b0;
    wait_idle("brk_drain", 200);
    chk("brk_starts", 32'(start_cnt - s0), 32'd2);

    // Reset during BUSY with four words queued.
    done_dly = 1000; cfg_baud_rate_cnt = 16'd0;
    step();
    for (int i = 0; i < 5; i++) push(DW'($urandom), 1'b0);
    cfg_baud_rate_cnt = 16'd10;
    wait_start("mid_start", 10);
    step(2);
    chk("mid_level", 32'(level), 32'd4);
    chk("mid_temt", 32'(temt), 32'd0);
    rst = 1'b1;
    #1;
    q_model.delete(); mdl_ovf = 1'b0;
    s0 = start_cnt;
    chk_reset_outs("midrst");
    step(2);
    rst = 1'b0;
    step(20);
    chk("post_rst_nostart", 32'(start_cnt - s0), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
